// File: rtl/tank_heading_ctrl.sv
// Heading controller for a tank sprite.
//
// Owns the 4-bit heading index (0..15, 22.5 degrees per step; 0 up, 4 left,
// 8 down, 12 right). In IDLE, holding exactly one of left/right rotates the
// heading once every ROT_PERIOD frame ticks. A seek request quantises an aim
// vector to the nearest heading, then turns toward it by the shortest path,
// one step per rotation period.
//
// Optional build macro SEEK_ABORT_EN: when defined, left or right asserted
// during QUANT or TURN abandons the seek (no seek_done, heading kept).
//
// Ports:
//   clk         system clock
//   reset       asynchronous active-low reset
//   frame_tick  one-cycle pulse per video frame
//   left        manual rotate, heading +1
//   right       manual rotate, heading -1
//   seek_valid  aim-vector request
//   seek_dx     signed aim x (right positive)
//   seek_dy     signed aim y (down positive)
//   seek_ready  request accepted when seek_valid && seek_ready
//   heading     current heading index
//   rotating    high while turning toward a seek target
//   seek_done   one-cycle pulse when a seek reaches its target
module tank_heading_ctrl #(
    parameter int unsigned ROT_PERIOD   = 4,
    parameter logic [3:0]  INIT_HEADING = 4'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       left,
    input  logic       right,
    input  logic       seek_valid,
    input  logic [9:0] seek_dx,
    input  logic [9:0] seek_dy,
    output logic       seek_ready,
    output logic [3:0] heading,
    output logic       rotating,
    output logic       seek_done
);

    localparam int unsigned    CW     = (ROT_PERIOD > 1) ? $clog2(ROT_PERIOD) : 1;
    localparam logic [CW-1:0]  RELOAD = CW'(ROT_PERIOD - 1);

    typedef enum logic [1:0] {IDLE, QUANT, TURN} state_t;

    state_t        state, state_next;
    logic [3:0]    heading_next, target, target_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [9:0]    dx_q, dy_q, dx_next, dy_next;
    logic          done_next;
    logic          abort;

    logic [9:0]    adx, ady, a, b;
    logic [12:0]   a13, b13;
    logic          x_major;
    logic [3:0]    off, quant;
    logic [3:0]    diff, turn_heading, manual_heading;

`ifdef SEEK_ABORT_EN
    assign abort = left | right;
`else
    assign abort = 1'b0;
`endif

    // Nearest-heading quantiser. Ratios b/a against 1/5 and 2/3 split each
    // 90-degree quadrant into the axis and +/-1, +/-2 neighbours.
    always_comb begin
        adx     = dx_q[9] ? (~dx_q + 10'd1) : dx_q;
        ady     = dy_q[9] ? (~dy_q + 10'd1) : dy_q;
        x_major = (adx >= ady);
        a       = x_major ? adx : ady;
        b       = x_major ? ady : adx;
        a13     = {3'b000, a};
        b13     = {3'b000, b};
        if (b13 * 13'd5 <= a13)
            off = 4'd0;
        else if (b13 * 13'd3 <= {a13[11:0], 1'b0})
            off = 4'd1;
        else
            off = 4'd2;

        if (dx_q == '0 && dy_q == '0)
            quant = heading;
        else if (x_major) begin
            if (dx_q[9]) quant = dy_q[9] ? 4'd4 - off  : 4'd4 + off;
            else         quant = dy_q[9] ? 4'd12 + off : 4'd12 - off;
        end else begin
            if (dy_q[9]) quant = dx_q[9] ? 4'd0 + off  : 4'd0 - off;
            else         quant = dx_q[9] ? 4'd8 - off  : 4'd8 + off;
        end
    end

    // Shortest-path step; a difference of exactly 8 resolves to +1.
    always_comb begin
        diff           = target - heading;
        turn_heading   = (diff != 4'd0 && diff <= 4'd8) ? heading + 4'd1 : heading - 4'd1;
        manual_heading = left ? heading + 4'd1 : heading - 4'd1;
    end

    // State register (plus datapath registers)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            heading   <= INIT_HEADING;
            target    <= '0;
            cnt       <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            seek_done <= 1'b0;
        end else begin
            state     <= state_next;
            heading   <= heading_next;
            target    <= target_next;
            cnt       <= cnt_next;
            dx_q      <= dx_next;
            dy_q      <= dy_next;
            seek_done <= done_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next   = state;
        heading_next = heading;
        target_next  = target;
        cnt_next     = cnt;
        dx_next      = dx_q;
        dy_next      = dy_q;
        done_next    = 1'b0;
        unique case (state)
            IDLE: begin
                if (seek_valid) begin
                    dx_next    = seek_dx;
                    dy_next    = seek_dy;
                    cnt_next   = '0;
                    state_next = QUANT;
                end else if (left ^ right) begin
                    if (frame_tick) begin
                        if (cnt == '0) begin
                            heading_next = manual_heading;
                            cnt_next     = RELOAD;
                        end else begin
                            cnt_next = cnt - CW'(1);
                        end
                    end
                end else begin
                    // Cleared so a fresh press steps on the very next tick.
                    cnt_next = '0;
                end
            end
            QUANT: begin
                target_next = quant;
                cnt_next    = '0;
                if (abort) begin
                    state_next = IDLE;
                end else if (quant == heading) begin
                    done_next  = 1'b1;
                    state_next = IDLE;
                end else begin
                    state_next = TURN;
                end
            end
            TURN: begin
                if (abort) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else if (frame_tick) begin
                    if (cnt == '0) begin
                        heading_next = turn_heading;
                        cnt_next     = RELOAD;
                        if (turn_heading == target) begin
                            done_next  = 1'b1;
                            cnt_next   = '0;
                            state_next = IDLE;
                        end
                    end else begin
                        cnt_next = cnt - CW'(1);
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        seek_ready = (state == IDLE);
        rotating   = (state == TURN);
    end

endmodule
